// File: rtl/seg7_pkg.sv
// Shared 7-segment types and constants, used by the scan driver, the
// binary-to-7-seg converter and seg7_decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef logic [6:0] seg_t;
  typedef seg_t [3:0] seg_bank_t;

  // Active-low one-hot anode enable for digit idx.
  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Slot prescaler: counts 0..SLOT_CYC-1 while enabled and flags the
// end-of-slot tick and the dead-time window at the start of each slot.
module seg7_tick_gen #(
  parameter int SLOT_CYC    = 50_000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic dead
);

  localparam int CW = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] DEAD = CW'(DEAD_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);
  assign dead = (cnt < DEAD);

endmodule

// File: rtl/seg7_scan_mux.sv
// 4-digit common-anode scan driver with frame-synchronous double buffering,
// anti-ghosting dead time and blink.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int DIGIT_HZ     = 1_000,
  parameter int DEAD_CYCLES  = 500,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       update,
  input  logic       blink,
  input  logic [6:0] seg3,
  input  logic [6:0] seg2,
  input  logic [6:0] seg1,
  input  logic [6:0] seg0,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame
);

  localparam int SLOT_CYC = CLK_FREQ_HZ / DIGIT_HZ;
  localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic          tick;
  logic          dead;
  logic          wrap;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          pending;
  seg_bank_t     shadow;
  seg_bank_t     active;

  seg7_tick_gen #(
    .SLOT_CYC   (SLOT_CYC),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .tick (tick),
    .dead (dead)
  );

  assign wrap = tick && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      pending   <= 1'b0;
      shadow    <= {4{SEG_BLANK}};
      active    <= {4{SEG_BLANK}};
      an        <= AN_OFF;
      seg       <= SEG_BLANK;
      frame     <= 1'b0;
    end else begin
      if (tick) idx <= idx + 2'd1;

      if (wrap) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      // A capture on the wrap cycle itself lands after the swap, so it stays pending.
      if (wrap && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (update) begin
        shadow  <= {seg3, seg2, seg1, seg0};
        pending <= 1'b1;
      end

      // Output stage, one cycle behind prescaler/index.
      frame <= wrap;
      if (!en || dead) begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
      end else begin
        an  <= (blink && blink_ph) ? AN_OFF : an_sel(idx);
        seg <= active[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: directed sequences plus randomized traffic checked
// every cycle against a time-based behavioural model.
module tb_seg7_scan_mux;

  localparam int SLOT = 10;
  localparam int DEAD = 2;
  localparam int BF   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       update = 1'b0;
  logic       blink = 1'b0;
  logic [6:0] seg3 = 7'h7F, seg2 = 7'h7F, seg1 = 7'h7F, seg0 = 7'h7F;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame;

  seg7_scan_mux #(
    .CLK_FREQ_HZ (1000),
    .DIGIT_HZ    (100),
    .DEAD_CYCLES (DEAD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .update(update),
    .blink (blink),
    .seg3  (seg3),
    .seg2  (seg2),
    .seg1  (seg1),
    .seg0  (seg0),
    .an    (an),
    .seg   (seg),
    .frame (frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: t counts enabled cycles since reset; slot, digit and
  // blink phase are plain arithmetic on t.
  int         t;
  logic [6:0] m_shadow[4];
  logic [6:0] m_active[4];
  bit         m_pend;
  bit         m_live = 1'b0;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_frame;

  always @(posedge clk) begin : model
    int p, d, ph;
    bit wrap;
    m_live = 1'b1;
    if (!rst_n) begin
      t = 0;
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] = 7'h7F;
        m_active[i] = 7'h7F;
      end
      m_pend  = 1'b0;
      e_an    = 4'hF;
      e_seg   = 7'h7F;
      e_frame = 1'b0;
    end else begin
      p    = t % SLOT;
      d    = (t / SLOT) % 4;
      ph   = (t / (4 * SLOT * BF)) % 2;
      wrap = en && (p == SLOT - 1) && (d == 3);
      e_frame = wrap;
      if (!en || p < DEAD) begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
      end else begin
        e_an  = (blink && ph == 1) ? 4'hF : ~(4'b0001 << d);
        e_seg = m_active[d];
      end
      if (wrap && m_pend) begin
        m_active = m_shadow;
        m_pend   = 1'b0;
      end
      if (update) begin
        m_shadow[0] = seg0;
        m_shadow[1] = seg1;
        m_shadow[2] = seg2;
        m_shadow[3] = seg3;
        m_pend      = 1'b1;
      end
      if (en) t++;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (m_live) begin
      checks++;
      if (an !== e_an || seg !== e_seg || frame !== e_frame) begin
        failures++;
        $display("FAIL model at %0t: an=%h seg=%h frame=%b, expected an=%h seg=%h frame=%b",
                 $time, an, seg, frame, e_an, e_seg, e_frame);
      end
    end
  endtask

  task automatic adv(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_frame(input int max);
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame !== 1'b1 && n < max);
    chk("frame_seen", {7'd0, frame}, 8'h01);
  endtask

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
  } vec_t;

  vec_t scan_tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cur;
    // Cycle offsets after a frame pulse, for patterns 40/79/24/30 on digits 0..3.
    scan_tbl[0] = '{1,  4'hF, 7'h7F};
    scan_tbl[1] = '{2,  4'hF, 7'h7F};
    scan_tbl[2] = '{3,  4'hE, 7'h40};
    scan_tbl[3] = '{10, 4'hE, 7'h40};
    scan_tbl[4] = '{11, 4'hF, 7'h7F};
    scan_tbl[5] = '{13, 4'hD, 7'h79};
    scan_tbl[6] = '{23, 4'hB, 7'h24};
    scan_tbl[7] = '{33, 4'h7, 7'h30};
    scan_tbl[8] = '{40, 4'h7, 7'h30};

    // Reset
    adv(3);
    chk("rst_an", {4'd0, an}, 8'h0F);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_frame", {7'd0, frame}, 8'h00);
    rst_n = 1'b1;
    adv(2);
    chk("rel_dead", {4'd0, an}, 8'h0F);
    adv(1);
    chk("rel_dig0", {4'd0, an}, 8'h0E);

    // Scan
    seg0 = 7'h40; seg1 = 7'h79; seg2 = 7'h24; seg3 = 7'h30; update = 1'b1;
    tick();
    update = 1'b0;
    wait_frame(60);
    cur = 0;
    foreach (scan_tbl[i]) begin
      adv(scan_tbl[i].k - cur);
      cur = scan_tbl[i].k;
      chk("scan_an", {4'd0, an}, {4'd0, scan_tbl[i].an});
      chk("scan_seg", {1'b0, seg}, {1'b0, scan_tbl[i].seg});
    end
    chk("scan_frame", {7'd0, frame}, 8'h01);

    // Tear-free update mid-frame
    adv(5);
    chk("tear_pre", {1'b0, seg}, 8'h40);
    adv(20);
    seg0 = 7'h12; update = 1'b1;
    tick();
    update = 1'b0;
    adv(9);
    chk("tear_slot3", {1'b0, seg}, 8'h30);
    wait_frame(60);
    adv(5);
    chk("tear_post", {1'b0, seg}, 8'h12);

    // Update coincident with wrap
    wait_frame(60);
    adv(10);
    seg0 = 7'h08; update = 1'b1;
    tick();
    update = 1'b0;
    adv(28);
    seg0 = 7'h03; update = 1'b1;
    tick();
    update = 1'b0;
    chk("coinc_frame", {7'd0, frame}, 8'h01);
    adv(5);
    chk("coinc_a", {1'b0, seg}, 8'h08);
    wait_frame(60);
    adv(5);
    chk("coinc_b", {1'b0, seg}, 8'h03);

    // Blink, counted from reset release
    rst_n = 1'b0;
    adv(2);
    rst_n = 1'b1;
    blink = 1'b1;
    adv(6);
    chk("blink_on", {4'd0, an}, 8'h0E);
    adv(80);
    chk("blink_off", {4'd0, an}, 8'h0F);
    adv(19);
    chk("blink_off_b", {4'd0, an}, 8'h0F);
    blink = 1'b0;
    adv(1);
    chk("blink_release", {4'd0, an}, 8'h0B);
    blink = 1'b1;
    adv(20);
    chk("blink_off2", {4'd0, an}, 8'h0F);
    adv(40);
    chk("blink_on2", {4'd0, an}, 8'h0E);
    blink = 1'b0;

    // Enable drop at prescaler 5
    adv(9);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("en_dark_an", {4'd0, an}, 8'h0F);
      chk("en_no_frame", {7'd0, frame}, 8'h00);
    end
    en = 1'b1;
    adv(1);
    chk("en_resume", {4'd0, an}, 8'h0D);
    adv(7);
    chk("en_next_slot", {4'd0, an}, 8'h0B);

    // Reset mid-frame drops a pending update
    seg0 = 7'h55; update = 1'b1;
    tick();
    update = 1'b0;
    rst_n = 1'b0;
    adv(1);
    chk("rstm_an", {4'd0, an}, 8'h0F);
    chk("rstm_seg", {1'b0, seg}, 8'h7F);
    adv(1);
    rst_n = 1'b1;
    adv(3);
    chk("rstm_idx0", {4'd0, an}, 8'h0E);
    wait_frame(60);
    adv(5);
    chk("rstm_drop", {1'b0, seg}, 8'h7F);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      en     = ($urandom_range(0, 15) != 0);
      update = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 199) == 0) blink = ~blink;
      seg0 = 7'($urandom);
      seg1 = 7'($urandom);
      seg2 = 7'($urandom);
      seg3 = 7'($urandom);
      tick();
    end
    rst_n = 1'b1; en = 1'b1; update = 1'b0;
    adv(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
